// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Round-robin arbiter and single-access sequencer in front of the
//            byte-addressed, big-endian data RAM. Two requesters (m0 = core
//            load/store unit, m1 = loader/debug port) share the RAM, one
//            transaction per grant. Each accepted request gets alignment and
//            range checks, one cycle of RAM strobes, and a held response.
// Ports    : CLK, reset (sync, active-low)
//            mX_req_{valid,ready,we,size,unsigned,addr,wdata}  request side
//            mX_rsp_{valid,ready,rdata,fault}                  response side
//            ram_{addr,wdata,memread,memwrite,storeops,rdata}  RAM side
// Revision : 1.0  initial release
// ============================================================================
module ram_arbiter #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        CLK,
  input  logic        reset,
  // requester 0
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic        m0_req_we,
  input  logic [1:0]  m0_req_size,
  input  logic        m0_req_unsigned,
  input  logic [31:0] m0_req_addr,
  input  logic [31:0] m0_req_wdata,
  output logic        m0_rsp_valid,
  input  logic        m0_rsp_ready,
  output logic [31:0] m0_rsp_rdata,
  output logic        m0_rsp_fault,
  // requester 1
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic        m1_req_we,
  input  logic [1:0]  m1_req_size,
  input  logic        m1_req_unsigned,
  input  logic [31:0] m1_req_addr,
  input  logic [31:0] m1_req_wdata,
  output logic        m1_rsp_valid,
  input  logic        m1_rsp_ready,
  output logic [31:0] m1_rsp_rdata,
  output logic        m1_rsp_fault,
  // RAM
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_memread,
  output logic        ram_memwrite,
  output logic [1:0]  ram_storeops,
  input  logic [31:0] ram_rdata
);

  // Store-op encodings shared with the RAM (defs.v STORE_B/H/W)
  localparam logic [1:0] STORE_B = 2'b00;
  localparam logic [1:0] STORE_H = 2'b01;
  localparam logic [1:0] STORE_W = 2'b10;

  localparam logic [1:0] SIZE_B  = 2'b00;
  localparam logic [1:0] SIZE_H  = 2'b01;
  localparam logic [1:0] SIZE_W  = 2'b10;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RESP    = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic        r_last_grant;
  logic        r_owner;
  logic        r_we;
  logic        r_uns;
  logic        r_fault;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic        w_sel;
  logic        w_sel_we;
  logic        w_sel_uns;
  logic [1:0]  w_sel_size;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [32:0] w_end_addr;
  logic        w_fault;
  logic [31:0] w_load_data;
  logic        w_owner_rsp_ready;

  // Round-robin grant, only offered while idle. On a tie the port that did
  // not win last time goes; last_grant resets to 1 so m0 wins the first tie.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == IDLE) begin
      if (m0_req_valid && m1_req_valid) begin
        w_grant0 = r_last_grant;
        w_grant1 = !r_last_grant;
      end else begin
        w_grant0 = m0_req_valid;
        w_grant1 = m1_req_valid;
      end
    end
  end

  assign w_accept    = w_grant0 | w_grant1;
  assign w_sel       = w_grant1;
  assign w_sel_we    = w_sel ? m1_req_we       : m0_req_we;
  assign w_sel_uns   = w_sel ? m1_req_unsigned : m0_req_unsigned;
  assign w_sel_size  = w_sel ? m1_req_size     : m0_req_size;
  assign w_sel_addr  = w_sel ? m1_req_addr     : m0_req_addr;
  assign w_sel_wdata = w_sel ? m1_req_wdata    : m0_req_wdata;
  assign w_owner_rsp_ready = r_owner ? m1_rsp_ready : m0_rsp_ready;

  // Fault check on the request being accepted. The end address is formed
  // 33 bits wide so an address near 2^32 cannot wrap into range.
  always_comb begin
    case (w_sel_size)
      SIZE_B:  w_end_addr = {1'b0, w_sel_addr} + 33'd1;
      SIZE_H:  w_end_addr = {1'b0, w_sel_addr} + 33'd2;
      default: w_end_addr = {1'b0, w_sel_addr} + 33'd4;
    endcase
    w_fault = (w_end_addr > 33'(MEM_BYTES));
    case (w_sel_size)
      SIZE_H:  if (w_sel_addr[0])          w_fault = 1'b1;
      SIZE_W:  if (w_sel_addr[1:0] != 2'b00) w_fault = 1'b1;
      SIZE_B:  ;
      default: w_fault = 1'b1;
    endcase
  end

  // Big-endian RAM: the addressed byte sits in the top lane.
  always_comb begin
    case (r_size)
      SIZE_B:  w_load_data = {{24{!r_uns & ram_rdata[31]}}, ram_rdata[31:24]};
      SIZE_H:  w_load_data = {{16{!r_uns & ram_rdata[31]}}, ram_rdata[31:16]};
      default: w_load_data = ram_rdata;
    endcase
    if (r_we || r_fault) w_load_data = 32'd0;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = ACCESS;
      ACCESS:  w_next_state = RESP;
      RESP:    if (w_owner_rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Request latch and response capture
  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_fault      <= 1'b0;
      r_size       <= 2'b00;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_rdata      <= 32'd0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_sel;
        r_owner      <= w_sel;
        r_we         <= w_sel_we;
        r_uns        <= w_sel_uns;
        r_fault      <= w_fault;
        r_size       <= w_sel_size;
        r_addr       <= w_sel_addr;
        r_wdata      <= w_sel_wdata;
      end
      if (r_state == ACCESS) r_rdata <= w_load_data;
    end
  end

  // Outputs. The write strobe is gated by reset so that no store lands on
  // the edge at which the block is being reset.
  always_comb begin
    m0_req_ready = w_grant0;
    m1_req_ready = w_grant1;
    m0_rsp_valid = 1'b0;
    m0_rsp_rdata = 32'd0;
    m0_rsp_fault = 1'b0;
    m1_rsp_valid = 1'b0;
    m1_rsp_rdata = 32'd0;
    m1_rsp_fault = 1'b0;
    ram_addr     = r_addr;
    ram_wdata    = r_wdata;
    ram_memread  = 1'b0;
    ram_memwrite = 1'b0;
    ram_storeops = STORE_B;
    case (r_state)
      ACCESS: begin
        ram_memwrite = r_we && !r_fault && reset;
        ram_memread  = !r_we && !r_fault;
        case (r_size)
          SIZE_B:  ram_storeops = STORE_B;
          SIZE_H:  ram_storeops = STORE_H;
          default: ram_storeops = STORE_W;
        endcase
      end
      RESP: begin
        if (r_owner) begin
          m1_rsp_valid = 1'b1;
          m1_rsp_rdata = r_rdata;
          m1_rsp_fault = r_fault;
        end else begin
          m0_rsp_valid = 1'b1;
          m0_rsp_rdata = r_rdata;
          m0_rsp_fault = r_fault;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Directed self-checking bench for ram_arbiter with a big-endian
//            byte RAM model (combinational read, write on the strobe).
// Revision : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int MEM_BYTES = 1024;
  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;
  localparam logic [1:0] SX = 2'b11;

  logic        CLK = 1'b0;
  logic        reset;
  logic        m0_req_valid, m0_req_ready, m0_req_we, m0_req_unsigned;
  logic [1:0]  m0_req_size;
  logic [31:0] m0_req_addr, m0_req_wdata, m0_rsp_rdata;
  logic        m0_rsp_valid, m0_rsp_ready, m0_rsp_fault;
  logic        m1_req_valid, m1_req_ready, m1_req_we, m1_req_unsigned;
  logic [1:0]  m1_req_size;
  logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_rdata;
  logic        m1_rsp_valid, m1_rsp_ready, m1_rsp_fault;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_memread, ram_memwrite;
  logic [1:0]  ram_storeops;

  logic [7:0]  mem [0:MEM_BYTES-1];
  logic [9:0]  ra;
  int          total = 0;
  int          bad = 0;
  int          wr_pulses = 0;

  ram_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .CLK(CLK), .reset(reset),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_size(m0_req_size), .m0_req_unsigned(m0_req_unsigned), .m0_req_addr(m0_req_addr),
    .m0_req_wdata(m0_req_wdata), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
    .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_fault(m0_rsp_fault),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_size(m1_req_size), .m1_req_unsigned(m1_req_unsigned), .m1_req_addr(m1_req_addr),
    .m1_req_wdata(m1_req_wdata), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
    .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_fault(m1_rsp_fault),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_memread(ram_memread),
    .ram_memwrite(ram_memwrite), .ram_storeops(ram_storeops), .ram_rdata(ram_rdata)
  );

  always #5 CLK = ~CLK;

  // RAM model: big-endian combinational read; writes land mid-cycle so the
  // strobe is sampled well away from the clock edge.
  assign ra = ram_addr[9:0];
  assign ram_rdata = {mem[ra], mem[ra + 10'd1], mem[ra + 10'd2], mem[ra + 10'd3]};

  always @(negedge CLK) begin
    if (ram_memwrite) begin
      wr_pulses = wr_pulses + 1;
      case (ram_storeops)
        SB: mem[ra] = ram_wdata[7:0];
        SH: begin
          mem[ra]         = ram_wdata[15:8];
          mem[ra + 10'd1] = ram_wdata[7:0];
        end
        default: begin
          mem[ra]         = ram_wdata[31:24];
          mem[ra + 10'd1] = ram_wdata[23:16];
          mem[ra + 10'd2] = ram_wdata[15:8];
          mem[ra + 10'd3] = ram_wdata[7:0];
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memw(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic drive_req(input int p, input logic v, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      m0_req_valid = v; m0_req_we = we; m0_req_size = sz;
      m0_req_unsigned = uns; m0_req_addr = a; m0_req_wdata = d;
    end else begin
      m1_req_valid = v; m1_req_we = we; m1_req_size = sz;
      m1_req_unsigned = uns; m1_req_addr = a; m1_req_wdata = d;
    end
  endtask

  function automatic logic rsp_v(input int p);
    return (p == 0) ? m0_rsp_valid : m1_rsp_valid;
  endfunction

  // One complete transaction on port p, starting 1 time unit after an edge
  // with the arbiter idle; checks grant, strobes, latency and response.
  task automatic do_txn(input string tag, input int p, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_f);
    int wp0;
    drive_req(p, 1'b1, we, sz, uns, a, d);
    #1;
    chk({tag, "_req_ready"}, (p == 0) ? m0_req_ready : m1_req_ready, 32'd1);
    wp0 = wr_pulses;
    @(posedge CLK); #1;                       // accept edge passed: ACCESS
    drive_req(p, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    chk({tag, "_acc_rspv"}, rsp_v(p), 32'd0);
    chk({tag, "_memread"}, ram_memread, 32'(!we && !exp_f));
    chk({tag, "_memwrite"}, ram_memwrite, 32'(we && !exp_f));
    chk({tag, "_ram_addr"}, ram_addr, a);
    if (we && !exp_f) begin
      chk({tag, "_storeops"}, ram_storeops, sz);
      chk({tag, "_ram_wdata"}, ram_wdata, d);
    end
    @(posedge CLK); #1;                       // RESP
    chk({tag, "_rsp_valid"}, rsp_v(p), 32'd1);
    chk({tag, "_other_rspv"}, rsp_v(1 - p), 32'd0);
    chk({tag, "_rdata"}, (p == 0) ? m0_rsp_rdata : m1_rsp_rdata, exp_rd);
    chk({tag, "_fault"}, (p == 0) ? m0_rsp_fault : m1_rsp_fault, 32'(exp_f));
    chk({tag, "_wr_pulses"}, 32'(wr_pulses - wp0), 32'(we && !exp_f));
    if (p == 0) m0_rsp_ready = 1'b1; else m1_rsp_ready = 1'b1;
    @(posedge CLK); #1;                       // back to IDLE
    m0_rsp_ready = 1'b0;
    m1_rsp_ready = 1'b0;
    chk({tag, "_rsp_done"}, rsp_v(p), 32'd0);
  endtask

  initial begin
    int own;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
    reset = 1'b0;
    drive_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    drive_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    m0_rsp_ready = 1'b0;
    m1_rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rspv", {m0_rsp_valid, m1_rsp_valid, m0_req_ready, m1_req_ready}, 32'd0);
    chk("rst_strobes", {ram_memread, ram_memwrite, ram_storeops}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    reset = 1'b1;

    // Word store/load
    do_txn("st_w", 0, 1'b1, SW, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    chk("mem_w10", memw(32'h10), 32'hDEADBEEF);
    do_txn("ld_w", 0, 1'b0, SW, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

    // Byte and half extension
    do_txn("st_b", 1, 1'b1, SB, 1'b0, 32'h21, 32'h00000080, 32'd0, 1'b0);
    do_txn("ld_bs", 0, 1'b0, SB, 1'b0, 32'h21, 32'd0, 32'hFFFFFF80, 1'b0);
    do_txn("ld_bu", 1, 1'b0, SB, 1'b1, 32'h21, 32'd0, 32'h00000080, 1'b0);
    do_txn("st_h", 0, 1'b1, SH, 1'b0, 32'h22, 32'h00008001, 32'd0, 1'b0);
    chk("mem_w20", memw(32'h20), 32'h00808001);
    do_txn("ld_hs", 0, 1'b0, SH, 1'b0, 32'h22, 32'd0, 32'hFFFF8001, 1'b0);
    do_txn("ld_hu", 0, 1'b0, SH, 1'b1, 32'h22, 32'd0, 32'h00008001, 1'b0);

    // Faults and range boundary
    do_txn("f_ldw12", 0, 1'b0, SW, 1'b0, 32'h12, 32'd0, 32'd0, 1'b1);
    do_txn("f_stw12", 0, 1'b1, SW, 1'b0, 32'h12, 32'h01020304, 32'd0, 1'b1);
    chk("mem_w10_kept", memw(32'h10), 32'hDEADBEEF);
    chk("mem_w14_kept", memw(32'h14), 32'h00000000);
    do_txn("f_ldh3ff", 0, 1'b0, SH, 1'b0, 32'h3FF, 32'd0, 32'd0, 1'b1);
    do_txn("f_sth3ff", 1, 1'b1, SH, 1'b0, 32'h3FF, 32'h0000ABCD, 32'd0, 1'b1);
    chk("mem_3ff_kept", 32'(mem[32'h3FF]), 32'd0);
    do_txn("f_size11", 0, 1'b1, SX, 1'b0, 32'h30, 32'hFFFFFFFF, 32'd0, 1'b1);
    chk("mem_w30_kept", memw(32'h30), 32'd0);
    do_txn("f_far", 0, 1'b0, SB, 1'b0, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1);
    do_txn("ok_ldw3fc", 0, 1'b0, SW, 1'b0, 32'h3FC, 32'd0, 32'd0, 1'b0);
    do_txn("ok_stb3ff", 0, 1'b1, SB, 1'b0, 32'h3FF, 32'h00000077, 32'd0, 1'b0);
    do_txn("ok_ldb3ff", 1, 1'b0, SB, 1'b1, 32'h3FF, 32'd0, 32'h00000077, 1'b0);

    // Round robin: reset so the first tie goes to m0, then alternate
    reset = 1'b0;
    @(posedge CLK); #1;
    reset = 1'b1;
    drive_req(0, 1'b1, 1'b0, SW, 1'b0, 32'h10, 32'd0);
    drive_req(1, 1'b1, 1'b0, SW, 1'b0, 32'h20, 32'd0);
    m0_rsp_ready = 1'b1;
    m1_rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      own = k % 2;
      chk("arb_ready0", m0_req_ready, 32'(own == 0));
      chk("arb_ready1", m1_req_ready, 32'(own == 1));
      @(posedge CLK); #1;
      chk("arb_busy", {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid}, 32'd0);
      @(posedge CLK); #1;
      chk("arb_own_rspv", rsp_v(own), 32'd1);
      chk("arb_other_rspv", rsp_v(1 - own), 32'd0);
      chk("arb_rdata", (own == 0) ? m0_rsp_rdata : m1_rsp_rdata,
          (own == 0) ? 32'hDEADBEEF : 32'h00808001);
      @(posedge CLK); #1;
    end
    m0_rsp_ready = 1'b0;
    m1_rsp_ready = 1'b0;

    // Back-pressure: m0 wins (m1 went last), hold rsp_ready low 5 cycles
    chk("bp_grant0", m0_req_ready, 32'd1);
    @(posedge CLK); #1;
    drive_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    @(posedge CLK); #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_rspv", m0_rsp_valid, 32'd1);
      chk("bp_rdata", m0_rsp_rdata, 32'hDEADBEEF);
      chk("bp_m1_ready", m1_req_ready, 32'd0);
      @(posedge CLK); #1;
    end
    m0_rsp_ready = 1'b1;
    #1;
    chk("bp_still_valid", m0_rsp_valid, 32'd1);
    @(posedge CLK); #1;
    m0_rsp_ready = 1'b0;
    chk("bp_released", m0_rsp_valid, 32'd0);
    chk("bp_m1_granted", m1_req_ready, 32'd1);
    drive_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    #1;
    chk("bp_m1_dropped", m1_req_ready, 32'd0);

    // Reset during the ACCESS cycle of a store
    do_txn("st_b40", 0, 1'b1, SB, 1'b0, 32'h40, 32'h0000005A, 32'd0, 1'b0);
    drive_req(0, 1'b1, 1'b1, SW, 1'b0, 32'h40, 32'h11223344);
    @(posedge CLK); #1;
    drive_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    chk("rst_acc_strobe", ram_memwrite, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_acc_gated", ram_memwrite, 32'd0);
    @(posedge CLK); #1;
    reset = 1'b1;
    chk("rst_mid_rspv", {m0_rsp_valid, m1_rsp_valid}, 32'd0);
    chk("rst_mid_mem", memw(32'h40), 32'h5A000000);
    chk("rst_mid_addr", ram_addr, 32'd0);
    drive_req(0, 1'b1, 1'b0, SB, 1'b0, 32'h40, 32'd0);
    drive_req(1, 1'b1, 1'b0, SB, 1'b0, 32'h40, 32'd0);
    #1;
    chk("rst_tie_m0", m0_req_ready, 32'd1);
    chk("rst_tie_m1", m1_req_ready, 32'd0);
    drive_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    drive_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    @(posedge CLK); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the byte-addressed, big-endian data RAM.
- Shares the RAM between the core load/store unit (m0) and the program loader/debug port (m1) using round-robin grants, one transaction per grant.
- Checks alignment and range, drives the RAM control signals for exactly one cycle per access, and returns load data sign- or zero-extended through a valid/ready response.

Parameters:
- MEM_BYTES, 1024: RAM size in bytes; any access touching a byte at or above this faults.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset: sampled low at a CLK posedge, the block resets.
- mX_req_valid  in  1  request valid (X = 0, 1; the same set exists for each requester).
- mX_req_ready  out  1  request accepted this cycle.
- mX_req_we  in  1  1 = store, 0 = load.
- mX_req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- mX_req_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
- mX_req_addr  in  32  byte address.
- mX_req_wdata  in  32  store data, right-justified.
- mX_rsp_valid  out  1  response valid.
- mX_rsp_ready  in  1  response consumed.
- mX_rsp_rdata  out  32  extended load data; 0 for stores and faults.
- mX_rsp_fault  out  1  misaligned, out-of-range or reserved size.
- ram_addr  out  32  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_memread  out  1  RAM read strobe.
- ram_memwrite  out  1  RAM write strobe.
- ram_storeops  out  2  `STORE_B / `STORE_H / `STORE_W from defs.v.
- ram_rdata  in  32  RAM combinational read, {mem[a], mem[a+1], mem[a+2], mem[a+3]}.

Behaviour:
- States: IDLE, ACCESS, RESP. Reset values:
  - state = IDLE; last_grant = 1 (so m0 wins the first tie).
  - All outputs 0, except ram_addr and ram_wdata, which reset to 0 and afterwards hold their latched values.
- Grant in IDLE (combinational):
  - One valid requester: grant it.
  - Both valid: grant the requester that is not last_grant.
  - mX_req_ready = 1 only for the granted requester, only in IDLE.
- Accept edge (valid && ready):
  - Latch we, size, unsigned, addr, wdata and owner; set last_grant = owner; go to ACCESS.
  - Compute fault at accept:
    - size == 11;
    - half with addr[0] != 0;
    - word with addr[1:0] != 0;
    - addr + bytes(size) > MEM_BYTES, computed 33 bits wide so there is no wrap.
- ACCESS (exactly one cycle):
  - ram_addr = latched addr.
  - ram_wdata = latched wdata.
  - ram_storeops = size mapped to `STORE_*.
  - ram_memwrite = we && !fault && reset. The reset gate ensures no write happens at an edge where reset is sampled low.
  - ram_memread = !we && !fault.
  - At the closing edge, capture the response data and go to RESP:
    - byte: ram_rdata[31:24], extended;
    - half: ram_rdata[31:16], extended;
    - word: ram_rdata.
  - Faulted requests still pass through ACCESS with both strobes low, so latency is fixed.
- RESP:
  - Owner sees mX_rsp_valid = 1, with rsp_rdata and rsp_fault stable; the other port's rsp_valid = 0.
  - Hold until mX_rsp_ready is sampled 1, then go to IDLE.
  - A new request is not accepted in that same cycle; minimum issue interval is 3 cycles.
- Latency: accept at edge N → RAM strobe during cycle N+1 → rsp_valid from N+2.
- Outside ACCESS: ram_memread = ram_memwrite = 0.
- A requester that drops valid before ready is ignored; no request is lost once accepted.
- Reset mid-operation (any state): at the edge where reset is sampled low → IDLE; pending response dropped; last_grant = 1.

Test Plan:
- m0 store word 0xDEADBEEF @0x10, then load word @0x10 → exactly one ram_memwrite pulse with ram_storeops = `STORE_W; rsp_valid 2 cycles after accept; rsp_rdata = 0xDEADBEEF, fault 0.
- Byte 0x80 stored @0x21; load byte signed @0x21 → 0xFFFFFF80; unsigned → 0x00000080. Half 0x8001 @0x22 signed → 0xFFFF8001.
- m0 and m1 both hold valid for 4 transactions → grants m0, m1, m0, m1 (the first tie after reset goes to m0); no response is ever asserted to the non-owner.
- Faults:
  - word @0x12 → fault 1, rdata 0, no strobe;
  - half @0x3FF with MEM_BYTES = 1024 → fault;
  - size 11 → fault;
  - RAM contents unchanged in all cases.
- Hold rsp_ready = 0 for 5 cycles → rsp_valid and data stay stable, m1_req_ready stays 0 throughout; ready = 1 → IDLE next edge.
- Assert reset low during the ACCESS cycle of a store @0x40 → no write (mem[0x40] keeps its old value); IDLE and all rsp_valid = 0 next cycle; the next tie grants m0.
